// File: rtl/frame_draw_scheduler.sv
// Per-frame draw sequencer: runs the player, alien and laser drawers in turn and
// owns display_ram port B, turning the granted drawer's pixel into a clipped write.
module frame_draw_scheduler #(
   parameter int unsigned SCREEN_WIDTH  = 640,
   parameter int unsigned SCREEN_HEIGHT = 480,
   parameter int unsigned NUM_DRAWERS   = 3,
   parameter int unsigned PHASE_TIMEOUT = 65535,
   parameter int unsigned ADDR_WIDTH    = 19
) (
   input  logic                  clock,
   input  logic                  global_reset_n,
   input  logic                  frame_tick,
   input  logic [2:0]            phase_enable,
   output logic [2:0]            drawer_start,
   input  logic [2:0]            drawer_valid,
   input  logic [29:0]           drawer_x,
   input  logic [26:0]           drawer_y,
   input  logic [11:0]           drawer_color,
   input  logic [2:0]            drawer_done,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [3:0]            write_data,
   output logic                  write_enable,
   output logic                  busy,
   output logic [1:0]            phase,
   output logic                  frame_overrun,
   output logic                  timeout_err
);

   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned C_W   = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = $clog2(PHASE_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT} state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   idx, idx_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [IDX_W:0]     sel;
   logic               wr_d, tmo_d, overrun;
   logic               g_valid, g_done, on_screen;
   logic [X_W-1:0]     g_x;
   logic [Y_W-1:0]     g_y;
   logic [C_W-1:0]     g_c;
   logic [ADDR_WIDTH-1:0] addr;

   // Lowest enabled drawer index at or above 'from'; MSB flags that one exists.
   function automatic logic [IDX_W:0] pick_next(input logic [2:0] en, input int unsigned from);
      logic [IDX_W:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_DRAWERS; i++) begin
         if (!r[IDX_W] && i >= from && 1'(en >> i))
            r = {1'b1, IDX_W'(i)};
      end
      return r;
   endfunction

   // Only the granted drawer's lanes are ever looked at.
   always_comb begin
      g_valid   = 1'(drawer_valid >> idx);
      g_done    = 1'(drawer_done >> idx);
      g_x       = X_W'(drawer_x >> (X_W * 32'(idx)));
      g_y       = Y_W'(drawer_y >> (Y_W * 32'(idx)));
      g_c       = C_W'(drawer_color >> (C_W * 32'(idx)));
      on_screen = (32'(g_x) < SCREEN_WIDTH) && (32'(g_y) < SCREEN_HEIGHT);
      addr      = ADDR_WIDTH'(g_y) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(g_x);
   end

   // Next-state logic: done is only honoured in RUN, which masks a stale level at launch.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      cnt_d   = cnt;
      sel     = '0;
      wr_d    = 1'b0;
      tmo_d   = 1'b0;
      overrun = frame_tick && (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (frame_tick) begin
               sel = pick_next(phase_enable, 32'd0);
               if (sel[IDX_W]) begin
                  state_d = S_LAUNCH;
                  idx_d   = sel[IDX_W-1:0];
               end
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt + CNT_W'(1);
            wr_d  = g_valid && on_screen;
            if (g_done) begin
               state_d = S_NEXT;
            end else if (cnt_d == CNT_W'(PHASE_TIMEOUT)) begin
               state_d = S_NEXT;
               tmo_d   = 1'b1;
            end
         end
         S_NEXT: begin
            sel = pick_next(phase_enable, 32'(idx) + 32'd1);
            if (sel[IDX_W]) begin
               state_d = S_LAUNCH;
               idx_d   = sel[IDX_W-1:0];
            end else begin
               state_d = S_IDLE;
               idx_d   = '1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state <= S_IDLE;
         idx   <= '1;
         cnt   <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         cnt   <= cnt_d;
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         drawer_start  <= '0;
         write_address <= '0;
         write_data    <= '0;
         write_enable  <= 1'b0;
         busy          <= 1'b0;
         phase         <= 2'd3;
         frame_overrun <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         drawer_start <= (state_d == S_LAUNCH) ? (3'b001 << idx_d) : 3'b000;
         busy         <= (state_d != S_IDLE);
         phase        <= (state_d == S_LAUNCH || state_d == S_RUN) ? idx_d : 2'd3;
         write_enable <= wr_d;
         if (wr_d) begin
            write_address <= addr;
            write_data    <= g_c;
         end
         if (overrun) frame_overrun <= 1'b1;
         if (tmo_d)   timeout_err   <= 1'b1;
      end
   end

endmodule
